// File: rtl/video_pkg.sv
// Shared types and default raster timing for the text display pipeline.
// Defaults describe a 64x8 px column layout on an 800x525 raster.
package video_pkg;
  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FP     = 80;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 112;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction
endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle as seen by the character generator stage.
interface video_timing_if;
  import video_pkg::*;

  logic             ce;
  logic [POS_W-1:0] h_pos;
  logic [POS_W-1:0] v_pos;
  logic             hblank;
  logic             vblank;
  logic             hsync;
  logic             vsync;
  logic             frame_start;
  logic             vblank_irq;

  modport master (
    input  ce,
    output h_pos, v_pos, hblank, vblank, hsync, vsync, frame_start, vblank_irq
  );
  modport slave (
    output ce,
    input  h_pos, v_pos, hblank, vblank, hsync, vsync, frame_start, vblank_irq
  );
endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: phase FSM with per-phase down-counter plus a position
// counter; blank/sync flags are registered alongside the position.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter bit POL      = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STEP,
  output logic [POS_W-1:0] POS,
  output logic             BLANK,
  output logic             SYNC,
  output logic             WRAP
);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC_LEN, BP);

  if (TOTAL > MAX_TOTAL || ACTIVE < 1 || FP < 1 || SYNC_LEN < 1 || BP < 1) begin : g_bad_params
    $error("video_axis_counter: phase lengths must be >= 1 and total <= %0d", MAX_TOTAL);
  end

  localparam logic [POS_W-1:0] LAST   = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] ACT_M1 = POS_W'(ACTIVE - 1);
  localparam logic [POS_W-1:0] FP_M1  = POS_W'(FP - 1);
  localparam logic [POS_W-1:0] SY_M1  = POS_W'(SYNC_LEN - 1);
  localparam logic [POS_W-1:0] BP_M1  = POS_W'(BP - 1);

  phase_e           phase_q, phase_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             blank_q, blank_d;
  logic             sync_q, sync_d;
  logic             at_last;

  assign at_last = (pos_q == LAST);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    blank_d = blank_q;
    sync_d  = sync_q;
    if (STEP) begin
      pos_d = at_last ? '0 : pos_q + 1'b1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        // Phase counter expiring loads the length of the phase being entered.
        case (phase_q)
          PH_ACTIVE: begin phase_d = PH_FRONT;  cnt_d = FP_M1;  end
          PH_FRONT:  begin phase_d = PH_SYNC;   cnt_d = SY_M1;  end
          PH_SYNC:   begin phase_d = PH_BACK;   cnt_d = BP_M1;  end
          PH_BACK:   begin phase_d = PH_ACTIVE; cnt_d = ACT_M1; end
        endcase
      end
      blank_d = (phase_d != PH_ACTIVE);
      sync_d  = (phase_d == PH_SYNC) ? POL : ~POL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q <= PH_ACTIVE;
      cnt_q   <= ACT_M1;
      pos_q   <= '0;
      blank_q <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign POS   = pos_q;
  assign BLANK = blank_q;
  assign SYNC  = sync_q;
  assign WRAP  = STEP && at_last;
endmodule

// File: rtl/video_timing.sv
// Raster timing generator: horizontal axis steps on CE, vertical axis steps
// on horizontal wrap. Frame-start and vblank interrupt are registered here.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  output logic [POS_W-1:0] H_POS,
  output logic [POS_W-1:0] V_POS,
  output logic             HBLANK,
  output logic             VBLANK,
  output logic             HSYNC_IN,
  output logic             VSYNC_IN,
  output logic             FRAME_START,
  output logic             VBLANK_IRQ
);
  localparam logic [POS_W-1:0] IRQ_LINE = POS_W'(V_ACTIVE - 1);

  logic h_wrap, v_wrap;
  logic frame_start_q, frame_start_d;
  logic irq_q, irq_d;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC_LEN(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
  ) u_h (
    .CLK(CLK), .RESET(RESET), .STEP(CE),
    .POS(H_POS), .BLANK(HBLANK), .SYNC(HSYNC_IN), .WRAP(h_wrap)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC_LEN(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
  ) u_v (
    .CLK(CLK), .RESET(RESET), .STEP(h_wrap),
    .POS(V_POS), .BLANK(VBLANK), .SYNC(VSYNC_IN), .WRAP(v_wrap)
  );

  // Both flags look one step ahead so they land in the same cycle as the position.
  always_comb begin
    frame_start_d = frame_start_q;
    irq_d         = 1'b0;
    if (CE) begin
      frame_start_d = h_wrap && v_wrap;
      irq_d         = h_wrap && (V_POS == IRQ_LINE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_start_q <= 1'b1;
      irq_q         <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      irq_q         <= irq_d;
    end
  end

  assign FRAME_START = frame_start_q;
  assign VBLANK_IRQ  = irq_q;
endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-timing instance and a 14x7 instance with
// inverted sync polarity, both checked every cycle against a raster model.
module tb_video_timing;
  import video_pkg::*;

  localparam int DHA = 512, DHF = 80, DHS = 96, DHB = 112, DHT = 800;
  localparam int DVA = 480, DVF = 10, DVS = 2,  DVB = 33,  DVT = 525;
  localparam int SHA = 8, SHF = 2, SHS = 2, SHB = 2, SHT = 14;
  localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1, SVT = 7;

  logic clk = 1'b0;
  logic rst_d, rst_s;
  bit   chk_en = 1'b0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  video_timing_if vd();
  video_timing_if vs();

  video_timing u_def (
    .CLK(clk), .RESET(rst_d), .CE(vd.ce),
    .H_POS(vd.h_pos), .V_POS(vd.v_pos), .HBLANK(vd.hblank), .VBLANK(vd.vblank),
    .HSYNC_IN(vd.hsync), .VSYNC_IN(vd.vsync),
    .FRAME_START(vd.frame_start), .VBLANK_IRQ(vd.vblank_irq)
  );

  video_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_sml (
    .CLK(clk), .RESET(rst_s), .CE(vs.ce),
    .H_POS(vs.h_pos), .V_POS(vs.v_pos), .HBLANK(vs.hblank), .VBLANK(vs.vblank),
    .HSYNC_IN(vs.hsync), .VSYNC_IN(vs.vsync),
    .FRAME_START(vs.frame_start), .VBLANK_IRQ(vs.vblank_irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int nxt_h(input int h, input int ht);
    return (h == ht - 1) ? 0 : h + 1;
  endfunction

  function automatic int nxt_v(input int h, input int v, input int ht, input int vt);
    if (h != ht - 1) return v;
    return (v == vt - 1) ? 0 : v + 1;
  endfunction

  // {hblank, vblank, hsync, vsync, frame_start} for a raster position
  function automatic logic [4:0] exp_flags(input int h, input int v,
      input int ha, input int hf, input int hs, input int va, input int vf, input int vsw,
      input bit hp, input bit vp);
    logic hsa, vsa;
    hsa = (h >= ha + hf) && (h < ha + hf + hs);
    vsa = (v >= va + vf) && (v < va + vf + vsw);
    return {h >= ha, v >= va, hsa ? hp : ~hp, vsa ? vp : ~vp, (h == 0) && (v == 0)};
  endfunction

  // Raster model: positions and the interrupt a CE edge should produce.
  int mh_d = 0, mv_d = 0, mh_s = 0, mv_s = 0;
  bit mirq_d = 1'b0, mirq_s = 1'b0;

  always @(posedge clk) begin
    if (rst_d) begin
      mh_d <= 0; mv_d <= 0; mirq_d <= 1'b0;
    end else if (vd.ce === 1'b1) begin
      mh_d   <= nxt_h(mh_d, DHT);
      mv_d   <= nxt_v(mh_d, mv_d, DHT, DVT);
      mirq_d <= (nxt_h(mh_d, DHT) == 0) && (nxt_v(mh_d, mv_d, DHT, DVT) == DVA);
    end else begin
      mirq_d <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_s) begin
      mh_s <= 0; mv_s <= 0; mirq_s <= 1'b0;
    end else if (vs.ce === 1'b1) begin
      mh_s   <= nxt_h(mh_s, SHT);
      mv_s   <= nxt_v(mh_s, mv_s, SHT, SVT);
      mirq_s <= (nxt_h(mh_s, SHT) == 0) && (nxt_v(mh_s, mv_s, SHT, SVT) == SVA);
    end else begin
      mirq_s <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d_hpos", vd.h_pos, mh_d);
      chk("d_vpos", vd.v_pos, mv_d);
      chk("d_flags", {vd.hblank, vd.vblank, vd.hsync, vd.vsync, vd.frame_start},
          exp_flags(mh_d, mv_d, DHA, DHF, DHS, DVA, DVF, DVS, 1'b0, 1'b0));
      chk("d_irq", vd.vblank_irq, mirq_d);
      chk("s_hpos", vs.h_pos, mh_s);
      chk("s_vpos", vs.v_pos, mv_s);
      chk("s_flags", {vs.hblank, vs.vblank, vs.hsync, vs.vsync, vs.frame_start},
          exp_flags(mh_s, mv_s, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1, 1'b1));
      chk("s_irq", vs.vblank_irq, mirq_s);
    end
  end

  // Frame period (CLKs between FRAME_START rises) and IRQ pulses per frame.
  int cyc = 0, last_rise = -1, last_period = 0, irq_cnt = 0, last_irq_cnt = -1;
  bit fs_prev = 1'b0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    fs_prev <= vs.frame_start;
    if (rst_s) begin
      last_rise <= -1;
      irq_cnt   <= 0;
    end else if (vs.frame_start && !fs_prev) begin
      if (last_rise >= 0) begin
        last_period  <= cyc - last_rise;
        last_irq_cnt <= irq_cnt;
      end
      last_rise <= cyc;
      irq_cnt   <= 0;
    end else begin
      irq_cnt <= irq_cnt + int'(vs.vblank_irq);
    end
  end

  initial begin
    int lows, first, last;
    bit found;
    rst_d = 1'b1; rst_s = 1'b1; vd.ce = 1'b1; vs.ce = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_d_pos", {vd.h_pos, vd.v_pos}, 0);
    chk("rst_d_flags", {vd.hblank, vd.vblank, vd.hsync, vd.vsync, vd.frame_start}, 5'b00111);
    chk("rst_d_irq", vd.vblank_irq, 0);
    chk("rst_s_flags", {vs.hblank, vs.vblank, vs.hsync, vs.vsync, vs.frame_start}, 5'b00001);
    rst_d = 1'b0; rst_s = 1'b0; chk_en = 1'b1;

    repeat (511) @(negedge clk);
    chk("d_h511", {vd.h_pos, vd.hblank}, {10'd511, 1'b0});
    @(negedge clk);
    chk("d_h512_hblank", {vd.h_pos, vd.hblank}, {10'd512, 1'b1});
    lows = 0; first = -1; last = -1;
    for (int i = 513; i <= 799; i++) begin
      @(negedge clk);
      if (vd.hsync == 1'b0) begin
        lows++;
        if (first < 0) first = int'(vd.h_pos);
        last = int'(vd.h_pos);
      end
    end
    chk("d_hsync_width", lows, 96);
    chk("d_hsync_first", first, 592);
    chk("d_hsync_last", last, 687);
    chk("d_h799", vd.h_pos, 799);
    @(negedge clk);
    chk("d_line_wrap", {vd.h_pos, vd.v_pos}, {10'd0, 10'd1});
    chk("s_period_ce1", last_period, SHT * SVT);
    chk("s_irq_per_frame_ce1", last_irq_cnt, 1);

    for (int i = 0; i < 1600; i++) begin
      vd.ce = (i % 4 == 0); vs.ce = (i % 4 == 0);
      @(negedge clk);
    end
    chk("s_period_ce4", last_period, 392);
    chk("s_irq_per_frame_ce4", last_irq_cnt, 1);

    vd.ce = 1'b1; vs.ce = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (vd.h_pos == 10'd300) found = 1'b1;
    end
    chk("d_reach_h300", found, 1);
    rst_d = 1'b1;
    @(negedge clk);
    chk("d_midrst_pos", {vd.h_pos, vd.v_pos}, 0);
    chk("d_midrst_flags", {vd.hblank, vd.vblank, vd.hsync, vd.vsync, vd.frame_start, vd.vblank_irq},
        6'b001110);
    rst_d = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (vs.vblank_irq) found = 1'b1;
    end
    chk("s_irq_seen", found, 1);
    chk("s_irq_pos", {vs.h_pos, vs.v_pos, vs.vblank}, {10'd0, 10'd4, 1'b1});
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (vs.h_pos == 10'd13 && vs.v_pos == 10'd6) found = 1'b1;
    end
    chk("s_reach_corner", found, 1);
    chk("s_corner_blank", {vs.hblank, vs.vblank}, 2'b11);
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    chk("s_wraprst_pos", {vs.h_pos, vs.v_pos}, 0);
    chk("s_wraprst_flags", {vs.hblank, vs.vblank, vs.hsync, vs.vsync, vs.frame_start, vs.vblank_irq},
        6'b000010);
    rst_s = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      vd.ce = 1'($urandom_range(0, 1));
      vs.ce = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
